seq_signed_divider: RTL and testbench

- Multicycle signed 32-bit divider for the CPU's DIV instruction.
- Sits directly downstream of the A/B operand registers and upstream of the HI/LO write-back muxes.
- The control FSM pulses start, then waits for done and writes quotient to LO and remainder to HI.
- Radix-2 restoring algorithm on magnitudes with a final sign-fix cycle; flags divide-by-zero for the exception path.

---
 rtl/seq_signed_divider.sv | 154 +++++++++++++++
 tb/tb_seq_signed_divider.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_signed_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_signed_divider
// Purpose  : Multicycle signed divider for the DIV instruction. Uses radix-2
//            restoring division on operand magnitudes, one quotient bit per
//            cycle, followed by a single sign-fix cycle. A zero divisor skips
//            the iteration and raises div_zero for the exception path.
// Ports    : clock, reset       - clock and synchronous active-high reset
//            start              - request, sampled only while idle
//            dividend           - signed numerator (register A)
//            divisor_in         - signed denominator (register B)
//            quotient           - signed quotient, truncated toward zero (LO)
//            remainder          - signed remainder, sign of dividend (HI)
//            busy               - operation in progress
//            done               - one-cycle completion pulse
//            div_zero           - divide-by-zero flag, held until next start
// Revision : 1.0 - initial release
// ============================================================================
module seq_signed_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_ZERO = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;         // partial remainder (magnitude)
  logic [WIDTH-1:0] quo_q, quo_d;         // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] dvs_q, dvs_d;         // divisor magnitude
  logic             qneg_q, qneg_d;       // quotient must be negated
  logic             rneg_q, rneg_d;       // remainder must be negated
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;

  // One extra bit so a magnitude of 2^(WIDTH-1) and the shifted-in bit fit;
  // trial[WIDTH] set means the subtraction went negative.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;
    div_zero_d  = div_zero_q;
    shifted     = {rem_q, quo_q[WIDTH-1]};
    trial       = shifted - {1'b0, dvs_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          div_zero_d = 1'b0;
          if (divisor_in != '0) begin
            // Negating the most negative value wraps to itself, which is
            // the correct unsigned magnitude.
            quo_d   = dividend[WIDTH-1]   ? -dividend   : dividend;
            dvs_d   = divisor_in[WIDTH-1] ? -divisor_in : divisor_in;
            qneg_d  = dividend[WIDTH-1] ^ divisor_in[WIDTH-1];
            rneg_d  = dividend[WIDTH-1];
            rem_d   = '0;
            cnt_d   = CW'(WIDTH);
            state_d = S_RUN;
          end else begin
            state_d = S_ZERO;
          end
        end
      end
      S_RUN: begin
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        quotient_d  = qneg_q ? -quo_q : quo_q;
        remainder_d = rneg_q ? -rem_q : rem_q;
        done_d      = 1'b1;
        state_d     = S_IDLE;
      end
      S_ZERO: begin
        div_zero_d = 1'b1;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = (state_q == S_RUN) || (state_q == S_FIX);
  assign done      = done_q;
  assign div_zero  = div_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_signed_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_signed_divider
// Purpose  : Self-checking bench for seq_signed_divider. The driver pushes the
//            expected result of every accepted operation into a queue; a
//            monitor pops and compares on each done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_signed_divider;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor_in = '0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;
  logic        div_zero;

  seq_signed_divider #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor_in (divisor_in),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic truncates toward zero and gives
  // the remainder the dividend's sign; the low 32 bits cover -2^31 / -1.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint la;
    longint lb;
    longint lq;
    longint lr;
    if (b == 32'd0) begin
      e.q  = last_q;
      e.r  = last_r;
      e.dz = 1'b1;
    end else begin
      la   = $signed(a);
      lb   = $signed(b);
      lq   = la / lb;
      lr   = la % lb;
      e.q  = lq[31:0];
      e.r  = lr[31:0];
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1, expected no completion");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
      end
    end
  end

  // Counts negedges from the accepting edge until done; latency 1 is the
  // negedge right after the accepting edge.
  task automatic wait_done(output int cyc, input bit is_zero);
    cyc = 0;
    forever begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        chk("div_zero_cleared_on_start", {31'd0, div_zero}, 32'd0);
        chk("busy_after_start", {31'd0, busy}, is_zero ? 32'd0 : 32'd1);
      end
      if (done) begin
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        break;
      end
      if (cyc > 100) begin
        vectors++;
        miscompares++;
        $display("FAIL done_timeout: got no done after %0d cycles, expected done", cyc);
        break;
      end
    end
  endtask

  // Called at a negedge with the DUT idle. Operands are scrambled after the
  // accepting edge to confirm they are captured only once.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit chk_lat);
    exp_t e;
    int   cyc;
    e = model(a, b);
    sb.push_back(e);
    last_q = e.q;
    last_r = e.r;
    dividend   = a;
    divisor_in = b;
    start      = 1'b1;
    @(posedge clock);
    #1;
    start      = 1'b0;
    dividend   = $urandom;
    divisor_in = $urandom;
    wait_done(cyc, b == 32'd0);
    if (chk_lat) begin
      chk("latency", cyc, (b == 32'd0) ? 32'd2 : 32'd34);
    end
  endtask

  initial begin
    int cyc;
    logic [31:0] a;
    logic [31:0] b;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("reset_quotient", quotient, 32'd0);
    chk("reset_remainder", remainder, 32'd0);
    chk("reset_flags", {29'd0, busy, done, div_zero}, 32'd0);

    issue(32'd100, 32'd7, 1'b1);
    issue(-32'sd100, 32'd7, 1'b1);
    issue(32'd100, -32'sd7, 1'b1);
    issue(32'd100, 32'd7, 1'b1);
    issue(32'd55, 32'd0, 1'b1);                 // holds 14/2, flags div_zero
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);  // overflow case
    issue(32'h8000_0000, 32'd1, 1'b1);

    // A second start mid-operation must be ignored.
    sb.push_back(model(32'd100, 32'd7));
    last_q = 32'd14;
    last_r = 32'd2;
    dividend   = 32'd100;
    divisor_in = 32'd7;
    start      = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (9) @(negedge clock);
    dividend   = 32'd9;
    divisor_in = 32'd3;
    start      = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(cyc, 1'b0);
    // Start in the done cycle is accepted.
    issue(32'd9, 32'd3, 1'b1);

    // Reset mid-operation: outputs clear and no completion follows.
    dividend   = 32'd100;
    divisor_in = 32'd7;
    start      = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    last_q = '0;
    last_r = '0;
    chk("midreset_quotient", quotient, 32'd0);
    chk("midreset_remainder", remainder, 32'd0);
    chk("midreset_flags", {29'd0, busy, done, div_zero}, 32'd0);
    repeat (40) @(negedge clock);   // monitor flags any stray done
    issue(32'd7, 32'd7, 1'b1);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = -$urandom_range(1, 15);
        3: a = 32'h8000_0000;
        4: begin a = $urandom_range(0, 1000); b = $urandom; end
        default: ;
      endcase
      issue(a, b, 1'b1);
    end

    @(negedge clock);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
